rgb2yuv: RTL and testbench
==========================

RGB2YUV -- requirements
Module: rgb2yuv

Interface
REQ-001 Port clk  in  1  sole clock; all state updates on its rising edge.
REQ-002 Port rst  in  1  reset, asynchronous and active-high.
REQ-003 Port clk_en  in  1  pipeline advance enable; when low, every register holds its value.
REQ-004 Port matrix_coefficients  in  8  sequence_display_extension code (ISO/IEC 13818-2 par. 6.3.6) selecting the conversion matrix.
REQ-005 Port chroma_422  in  1  1 = cosited 4:2:2 chroma decimation, 0 = 4:4:4.
REQ-006 Ports r, g, b  in  8 each  unsigned full-range input pixel.
REQ-007 Ports pixel_en_in, h_sync_in, v_sync_in  in  1 each  input timing.
REQ-008 Ports y, u, v  out  8 each  studio-range output (u = Cb, v = Cr).
REQ-009 Ports pixel_en_out, h_sync_out, v_sync_out  out  1 each  input timing delayed to match y/u/v.

Function
REQ-010 The block SHALL register matrix_coefficients[2:0] as mat_coeff each clk_en cycle; a value above 7 SHALL register as 0.
REQ-011 mat_coeff 0, 1 and 7 SHALL select the BT.709 set: yr 5983, yg 20128, yb 2032, cbr 3298, cbg 11094, crg 13073, crb 1319, cbb = crr = 14392.
REQ-012 mat_coeff 2-6 SHALL select the BT.601 set: yr 8415, yg 16520, yb 3208, cbr 4857, cbg 9535, crg 12052, crb 2340, cbb = crr = 14392.
REQ-013 Y SHALL be ((yr*R + yg*G + yb*B + 16384) >>> 15) + 16.
REQ-014 Cb SHALL be ((cbb*B - cbr*R - cbg*G + 16384) >>> 15) + 128.
REQ-015 Cr SHALL be ((crr*R - crg*G - crb*B + 16384) >>> 15) + 128.
REQ-016 All sums SHALL be signed with at least 27 bits, so no intermediate overflows; >>> is an arithmetic (floor) shift.
REQ-017 Y SHALL be clipped to 16..235; Cb and Cr SHALL be clipped to 16..240.
REQ-018 The pipeline SHALL have 4 stages, each advancing once per clk_en: input register, products, sums plus rounding, clip plus offset.
REQ-019 Latency SHALL be exactly 4 clk_en cycles from r/g/b to y/u/v, with one result per clk_en cycle.
REQ-020 pixel_en, h_sync and v_sync SHALL pass through a 4-deep clk_en shift register, aligned with y/u/v.
REQ-021 A phase flag at the output stage SHALL hold 0 while the aligned pixel_en is 0, and SHALL toggle on each clk_en cycle in which the aligned pixel_en is 1.
REQ-022 When chroma_422 = 1 and phase = 1, u/v SHALL repeat the previous (phase 0) u/v; y SHALL be unaffected.
REQ-023 When chroma_422 = 0, u/v SHALL update on every pixel.
REQ-024 A change of chroma_422 or matrix_coefficients SHALL take effect within 2 clk_en cycles without corrupting the timing outputs.

Reset
REQ-025 While rst = 1, all pipeline registers, the phase flag and mat_coeff SHALL be 0.
REQ-026 While rst = 1, y, u, v and all timing outputs SHALL be 0, asynchronously.
REQ-027 Reset asserted mid-line SHALL discard all in-flight pixels; the first output after release SHALL appear 4 clk_en cycles after the first new input.

Structure
REQ-028 The BT.709 and BT.601 coefficient sets, the offsets (16, 128), the clip limits and the rounding constant 16384 SHALL live in a shared package, yuv_pkg.
REQ-029 One sub-module, rgb2yuv_clip (parameterised lower and upper limit, 1-cycle registered), SHALL be instantiated three times.

Verification
REQ-030 RGB (255,255,255), any matrix -> YUV (235,128,128) after 4 clk_en.
REQ-031 RGB (0,0,0) -> YUV (16,128,128).
REQ-032 RGB (255,0,0): matrix_coefficients 1 -> (63,102,240); matrix_coefficients 6 -> (81,90,240).
REQ-033 matrix_coefficients 200 -> results identical to code 0.
REQ-034 clk_en toggling 1010..., pixel_en pulse of 3 pixels -> pixel_en_out pulse of 3 clk_en cycles, outputs held while clk_en = 0.
REQ-035 chroma_422 = 1, alternating red/blue line -> u/v fixed at the red values (102,240) for every pixel pair; rst asserted mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/yuv_pkg.sv
// Shared constants for the RGB -> studio-range YCbCr converter:
// coefficient sets, offsets, clip limits and the rounding term.
package yuv_pkg;

  typedef struct packed {
    logic [14:0] yr, yg, yb;
    logic [14:0] cbr, cbg, cbb;
    logic [14:0] crr, crg, crb;
  } coeff_t;

  typedef struct packed {
    logic pe;
    logic hs;
    logic vs;
  } timing_t;

  localparam coeff_t BT709 = '{
    yr: 15'd5983, yg: 15'd20128, yb: 15'd2032,
    cbr: 15'd3298, cbg: 15'd11094, cbb: 15'd14392,
    crr: 15'd14392, crg: 15'd13073, crb: 15'd1319};

  localparam coeff_t BT601 = '{
    yr: 15'd8415, yg: 15'd16520, yb: 15'd3208,
    cbr: 15'd4857, cbg: 15'd9535, cbb: 15'd14392,
    crr: 15'd14392, crg: 15'd12052, crb: 15'd2340};

  localparam int Y_OFS = 16;
  localparam int C_OFS = 128;
  localparam int Y_MIN = 16;
  localparam int Y_MAX = 235;
  localparam int C_MIN = 16;
  localparam int C_MAX = 240;
  localparam int SUM_W = 28;
  localparam logic signed [SUM_W-1:0] ROUND = 28'sd16384;

  // Codes 2..6 are the SMPTE 170M / BT.470 family; everything else is BT.709.
  function automatic coeff_t sel_coeff(input logic [2:0] m);
    return (m >= 3'd2 && m <= 3'd6) ? BT601 : BT709;
  endfunction

endpackage

// File: rtl/rgb2yuv_if.sv
// Pixel bus: RGB and timing in, YCbCr and delayed timing out.
interface rgb2yuv_if;
  logic [7:0] r, g, b;
  logic       pixel_en_in, h_sync_in, v_sync_in;
  logic [7:0] y, u, v;
  logic       pixel_en_out, h_sync_out, v_sync_out;

  modport master (
    output r, g, b, pixel_en_in, h_sync_in, v_sync_in,
    input  y, u, v, pixel_en_out, h_sync_out, v_sync_out
  );

  modport slave (
    input  r, g, b, pixel_en_in, h_sync_in, v_sync_in,
    output y, u, v, pixel_en_out, h_sync_out, v_sync_out
  );
endinterface

// File: rtl/rgb2yuv_clip.sv
// Output stage for one component: drop the 15 fraction bits, add the
// offset, clip to [LO, HI] and register. i_hold freezes the register.
module rgb2yuv_clip #(
  parameter int W   = 28,
  parameter int LO  = 16,
  parameter int HI  = 235,
  parameter int OFS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clk_en,
  input  logic                i_hold,
  input  logic signed [W-1:0] i_val,
  output logic [7:0]          o_val
);

  logic signed [W-1:0] w_shift;
  logic signed [W-1:0] w_sum;
  logic [7:0]          w_clip;

  assign w_shift = i_val >>> 15;
  assign w_sum   = w_shift + W'(OFS);

  always_comb begin
    w_clip = w_sum[7:0];
    if (w_sum < W'(LO))      w_clip = 8'(LO);
    else if (w_sum > W'(HI)) w_clip = 8'(HI);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    o_val <= '0;
    else if (clk_en && !i_hold) o_val <= w_clip;
  end

endmodule

// File: rtl/rgb2yuv.sv
// Four-stage RGB -> YCbCr converter (input reg, products, sums, clip)
// with matched timing delay and optional cosited 4:2:2 chroma decimation.
module rgb2yuv
  import yuv_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_en,
  input  logic [7:0] matrix_coefficients,
  input  logic       chroma_422,
  rgb2yuv_if.slave   pix
);

  function automatic logic [22:0] mul(input logic [14:0] c, input logic [7:0] x);
    return {8'd0, c} * {15'd0, x};
  endfunction

  function automatic logic signed [SUM_W-1:0] sx(input logic [22:0] p);
    return $signed({5'd0, p});
  endfunction

  logic [2:0]              r_mat;
  logic                    r_c422;
  logic [7:0]              r_r, r_g, r_b;
  logic [8:0][22:0]        r_prod;
  logic signed [SUM_W-1:0] r_sy, r_scb, r_scr;
  timing_t [3:0]           r_tim;
  logic                    r_phase;
  coeff_t                  w_cf;
  logic                    w_hold;
  logic [7:0]              w_y, w_u, w_v;

  assign w_cf = sel_coeff(r_mat);

  // Stage 1: capture pixel together with the matrix it must be converted with.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mat  <= '0;
      r_c422 <= 1'b0;
      r_r    <= '0;
      r_g    <= '0;
      r_b    <= '0;
    end else if (clk_en) begin
      r_mat  <= (matrix_coefficients > 8'd7) ? 3'd0 : matrix_coefficients[2:0];
      r_c422 <= chroma_422;
      r_r    <= pix.r;
      r_g    <= pix.g;
      r_b    <= pix.b;
    end
  end

  // Stage 2: all nine products.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_prod <= '0;
    else if (clk_en) begin
      r_prod[0] <= mul(w_cf.yr,  r_r);
      r_prod[1] <= mul(w_cf.yg,  r_g);
      r_prod[2] <= mul(w_cf.yb,  r_b);
      r_prod[3] <= mul(w_cf.cbr, r_r);
      r_prod[4] <= mul(w_cf.cbg, r_g);
      r_prod[5] <= mul(w_cf.cbb, r_b);
      r_prod[6] <= mul(w_cf.crr, r_r);
      r_prod[7] <= mul(w_cf.crg, r_g);
      r_prod[8] <= mul(w_cf.crb, r_b);
    end
  end

  // Stage 3: signed sums with the rounding term folded in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sy  <= '0;
      r_scb <= '0;
      r_scr <= '0;
    end else if (clk_en) begin
      r_sy  <= sx(r_prod[0]) + sx(r_prod[1]) + sx(r_prod[2]) + ROUND;
      r_scb <= sx(r_prod[5]) - sx(r_prod[3]) - sx(r_prod[4]) + ROUND;
      r_scr <= sx(r_prod[6]) - sx(r_prod[7]) - sx(r_prod[8]) + ROUND;
    end
  end

  // Timing delay line; r_tim[2] is the pixel entering the output stage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tim   <= '0;
      r_phase <= 1'b0;
    end else if (clk_en) begin
      r_tim[0] <= '{pe: pix.pixel_en_in, hs: pix.h_sync_in, vs: pix.v_sync_in};
      r_tim[3:1] <= r_tim[2:0];
      r_phase  <= r_tim[2].pe ? ~r_phase : 1'b0;
    end
  end

  assign w_hold = r_c422 & r_phase & r_tim[2].pe;

  rgb2yuv_clip #(.W(SUM_W), .LO(Y_MIN), .HI(Y_MAX), .OFS(Y_OFS)) u_clip_y (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_hold(1'b0), .i_val(r_sy), .o_val(w_y));
  rgb2yuv_clip #(.W(SUM_W), .LO(C_MIN), .HI(C_MAX), .OFS(C_OFS)) u_clip_u (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_hold(w_hold), .i_val(r_scb), .o_val(w_u));
  rgb2yuv_clip #(.W(SUM_W), .LO(C_MIN), .HI(C_MAX), .OFS(C_OFS)) u_clip_v (
    .clk(clk), .rst(rst), .clk_en(clk_en), .i_hold(w_hold), .i_val(r_scr), .o_val(w_v));

  assign pix.y            = w_y;
  assign pix.u            = w_u;
  assign pix.v            = w_v;
  assign pix.pixel_en_out = r_tim[3].pe;
  assign pix.h_sync_out   = r_tim[3].hs;
  assign pix.v_sync_out   = r_tim[3].vs;

endmodule

// File: tb/tb_rgb2yuv.sv
// Randomized bench for rgb2yuv against an integer-arithmetic reference model.
module tb_rgb2yuv;

  logic       clk = 1'b0;
  logic       rst;
  logic       clk_en;
  logic [7:0] mc;
  logic       c422;

  rgb2yuv_if pix();

  rgb2yuv dut (
    .clk(clk), .rst(rst), .clk_en(clk_en),
    .matrix_coefficients(mc), .chroma_422(c422), .pix(pix));

  always #5 clk = ~clk;

  typedef struct {
    int r, g, b;
    bit pe, hs, vs;
    int mat;
    bit c;
  } rec_t;

  rec_t q[$];
  int   ey, eu, ev;
  bit   epe, ehs, evs, phase;
  int   n_chk = 0, n_fail = 0;
  bit   red_mode = 0;
  bit   cur_c = 0;
  int   pe_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input int exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int clipv(input int x, input int lo, input int hi);
    return (x < lo) ? lo : ((x > hi) ? hi : x);
  endfunction

  task automatic ref_yuv(input rec_t t, output int y, output int u, output int v);
    int m, yr, yg, yb, cbr, cbg, crg, crb;
    int k;
    k = 14392;
    m = (t.mat > 7) ? 0 : t.mat;
    if (m == 0 || m == 1 || m == 7) begin
      yr = 5983; yg = 20128; yb = 2032; cbr = 3298; cbg = 11094; crg = 13073; crb = 1319;
    end else begin
      yr = 8415; yg = 16520; yb = 3208; cbr = 4857; cbg = 9535; crg = 12052; crb = 2340;
    end
    y = clipv(((yr*t.r + yg*t.g + yb*t.b + 16384) >>> 15) + 16, 16, 235);
    u = clipv(((k*t.b - cbr*t.r - cbg*t.g + 16384) >>> 15) + 128, 16, 240);
    v = clipv(((k*t.r - crg*t.g - crb*t.b + 16384) >>> 15) + 128, 16, 240);
  endtask

  function automatic rec_t mk(input int r, input int g, input int b, input bit pe,
                              input bit hs, input bit vs, input int mat, input bit c);
    rec_t t;
    t.r = r; t.g = g; t.b = b; t.pe = pe; t.hs = hs; t.vs = vs; t.mat = mat; t.c = c;
    return t;
  endfunction

  function automatic int rnd8();
    int s;
    s = $urandom_range(0, 7);
    return (s == 0) ? 0 : ((s == 1) ? 255 : int'($urandom_range(0, 255)));
  endfunction

  function automatic rec_t rnd_px(input bit pe, input int mat, input bit c, input bit vs);
    return mk(rnd8(), rnd8(), rnd8(), pe, 1'b0, vs, mat, c);
  endfunction

  // After reset the pipeline behaves as if it held idle black pixels.
  task automatic model_reset();
    q.delete();
    for (int i = 0; i < 3; i++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0));
    ey = 0; eu = 0; ev = 0; epe = 0; ehs = 0; evs = 0; phase = 0;
  endtask

  task automatic cyc(input bit en, input rec_t t);
    rec_t o;
    int y, u, v;
    clk_en = en;
    pix.r = 8'(t.r); pix.g = 8'(t.g); pix.b = 8'(t.b);
    pix.pixel_en_in = t.pe; pix.h_sync_in = t.hs; pix.v_sync_in = t.vs;
    mc = 8'(t.mat); c422 = t.c;
    @(posedge clk); #1;
    if (en) begin
      q.push_back(t);
      o = q.pop_front();
      ref_yuv(o, y, u, v);
      ey = y;
      if (!(o.c && o.pe && phase)) begin eu = u; ev = v; end
      epe = o.pe; ehs = o.hs; evs = o.vs;
      phase = o.pe ? !phase : 1'b0;
      if (pix.pixel_en_out) pe_cnt++;
    end
    chk("y", pix.y, ey);
    chk("u", pix.u, eu);
    chk("v", pix.v, ev);
    chk("pe_out", pix.pixel_en_out, int'(epe));
    chk("hs_out", pix.h_sync_out, int'(ehs));
    chk("vs_out", pix.v_sync_out, int'(evs));
    if (red_mode && pix.pixel_en_out) begin
      chk("c422_u", pix.u, 102);
      chk("c422_v", pix.v, 240);
    end
  endtask

  task automatic idle(input int n, input int mat);
    for (int i = 0; i < n; i++) cyc(1'b1, rnd_px(1'b0, mat, cur_c, 1'b0));
  endtask

  // mode: 0 = clk_en always on, 1 = 1010 toggling, 2 = random gaps.
  // kind: 0 = random pixels, 1 = alternating red/blue.
  task automatic line(input int n, input int mat, input bit c_new, input int mode, input int kind);
    rec_t t;
    bit vs;
    vs = 1'($urandom_range(0, 1));
    cyc(1'b1, mk(rnd8(), rnd8(), rnd8(), 1'b0, 1'b1, vs, mat, cur_c));
    idle(2, mat);
    cur_c = c_new;
    idle(2, mat);
    for (int i = 0; i < n; i++) begin
      if (kind == 1) t = (i % 2 == 0) ? mk(255, 0, 0, 1, 0, vs, mat, cur_c)
                                      : mk(0, 0, 255, 1, 0, vs, mat, cur_c);
      else t = rnd_px(1'b1, mat, cur_c, vs);
      if (mode == 2) while ($urandom_range(0, 3) == 0) cyc(1'b0, rnd_px(1'b1, 3, cur_c, 1'b1));
      cyc(1'b1, t);
      if (mode == 1) cyc(1'b0, rnd_px(1'b0, 6, cur_c, 1'b1));
    end
  endtask

  task automatic px(input string tag, input int r, input int g, input int b, input int mat,
                    input int xy, input int xu, input int xv);
    cur_c = 0;
    idle(5, mat);
    cyc(1'b1, mk(r, g, b, 1, 0, 0, mat, 0));
    idle(3, mat);
    chk({tag, "_pe"}, pix.pixel_en_out, 1);
    chk({tag, "_y"}, pix.y, xy);
    chk({tag, "_u"}, pix.u, xu);
    chk({tag, "_v"}, pix.v, xv);
  endtask

  initial begin
    int m;
    rst = 1'b1; clk_en = 1'b0; mc = '0; c422 = 1'b0;
    pix.r = '0; pix.g = '0; pix.b = '0;
    pix.pixel_en_in = 1'b0; pix.h_sync_in = 1'b0; pix.v_sync_in = 1'b0;
    #12;
    chk("rst_y", pix.y, 0);   chk("rst_u", pix.u, 0);   chk("rst_v", pix.v, 0);
    chk("rst_pe", pix.pixel_en_out, 0);
    chk("rst_hs", pix.h_sync_out, 0);
    chk("rst_vs", pix.v_sync_out, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();

    px("white709", 255, 255, 255, 1, 235, 128, 128);
    px("white601", 255, 255, 255, 5, 235, 128, 128);
    px("black", 0, 0, 0, 2, 16, 128, 128);
    px("red709", 255, 0, 0, 1, 63, 102, 240);
    px("red601", 255, 0, 0, 6, 81, 90, 240);
    px("red_m200", 255, 0, 0, 200, 63, 102, 240);

    idle(4, 1);
    pe_cnt = 0;
    line(3, 1, 1'b0, 1, 0);
    idle(6, 1);
    chk("pe_pulse", pe_cnt, 3);

    red_mode = 1;
    line(6, 1, 1'b1, 0, 1);
    idle(5, 1);
    red_mode = 0;

    for (int l = 0; l < 25; l++) begin
      m = ($urandom_range(0, 3) == 0) ? int'($urandom_range(8, 255)) : int'($urandom_range(0, 7));
      line($urandom_range(1, 16), m, 1'($urandom_range(0, 1)), $urandom_range(0, 2), 0);
      if (l == 12) begin
        for (int i = 0; i < 5; i++) cyc(1'b1, rnd_px(1'b1, 6, cur_c, 1'b1));
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_y", pix.y, 0);  chk("mid_rst_u", pix.u, 0);  chk("mid_rst_v", pix.v, 0);
        chk("mid_rst_pe", pix.pixel_en_out, 0);
        chk("mid_rst_hs", pix.h_sync_out, 0);
        chk("mid_rst_vs", pix.v_sync_out, 0);
        @(posedge clk); @(posedge clk); #1;
        chk("mid_rst_hold_y", pix.y, 0);
        rst = 1'b0;
        model_reset();
      end
    end
    idle(6, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
